io_bus_arbiter: RTL and testbench

- Shares the single CPU-side port of the I/O bus sequencer (the byte-serialising iobus engine) between two requesters.
  - m0: CPU core.
  - m1: DMA / debug I/O master.
- Round-robin arbitration; only one transaction is in flight at a time. Each transaction is issued to the sequencer as a one-cycle strobe.
- Watchdog timeout frees a requester if the downstream transaction never completes, for example when io_wait is stuck.

---
 rtl/io_bus_arbiter.sv | 115 +++++++++++
 tb/tb_io_bus_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin share of the iobus sequencer port between two requesters,
// one transaction in flight, with a BUSY watchdog that frees a stuck requester.
module io_bus_arbiter #(
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_read_do,
  input  logic [15:0] m0_read_address,
  input  logic [2:0]  m0_read_length,
  output logic [31:0] m0_read_data,
  output logic        m0_read_done,
  input  logic        m0_write_do,
  input  logic [15:0] m0_write_address,
  input  logic [2:0]  m0_write_length,
  input  logic [31:0] m0_write_data,
  output logic        m0_write_done,
  input  logic        m1_read_do,
  input  logic [15:0] m1_read_address,
  input  logic [2:0]  m1_read_length,
  output logic [31:0] m1_read_data,
  output logic        m1_read_done,
  input  logic        m1_write_do,
  input  logic [15:0] m1_write_address,
  input  logic [2:0]  m1_write_length,
  input  logic [31:0] m1_write_data,
  output logic        m1_write_done,
  output logic        io_read_do,
  output logic        io_write_do,
  output logic [15:0] io_address,
  output logic [2:0]  io_length,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_read_done,
  input  logic        io_write_done,
  output logic        timeout_err,
  output logic        grant
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RELEASE, DRAIN} state_t;
  state_t state, state_n;
  logic last_grant, kind_wr;
  logic [CW-1:0] cnt;
  logic pend0, pend1, go, sel, sel_wr, hit, fire, fin;
  logic [15:0] sel_addr;
  logic [2:0] sel_len;
  always_comb begin
    pend0 = m0_read_do | m0_write_do;
    pend1 = m1_read_do | m1_write_do;
    go = pend0 | pend1;
    sel = (pend0 & pend1) ? ~last_grant : pend1;
    sel_wr = sel ? m1_write_do : m0_write_do;
    sel_addr = sel_wr ? (sel ? m1_write_address : m0_write_address)
                      : (sel ? m1_read_address : m0_read_address);
    sel_len = sel_wr ? (sel ? m1_write_length : m0_write_length)
                     : (sel ? m1_read_length : m0_read_length);
    hit = kind_wr ? io_write_done : io_read_done;
    // a done landing on the final watchdog cycle still counts as a normal completion
    fire = (TIMEOUT != 0) && (state == BUSY) && !hit && (cnt == CW'(TIMEOUT - 1));
    fin = (state == BUSY) && (hit || fire);
    state_n = state;
    case (state)
      IDLE:    state_n = go ? ISSUE : IDLE;
      ISSUE:   state_n = BUSY;
      BUSY:    state_n = hit ? RELEASE : fire ? DRAIN : BUSY;
      RELEASE: state_n = IDLE;
      DRAIN:   state_n = hit ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_read_do <= 1'b0;
      io_write_do <= 1'b0;
      io_address <= '0;
      io_length <= '0;
      io_write_data <= '0;
      kind_wr <= 1'b0;
      grant <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      m0_read_done <= 1'b0;
      m0_write_done <= 1'b0;
      m1_read_done <= 1'b0;
      m1_write_done <= 1'b0;
      m0_read_data <= '0;
      m1_read_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      io_read_do <= (state == IDLE) && go && !sel_wr;
      io_write_do <= (state == IDLE) && go && sel_wr;
      cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
      if (state == IDLE && go) begin
        io_address <= sel_addr;
        io_length <= sel_len;
        io_write_data <= sel ? m1_write_data : m0_write_data;
        kind_wr <= sel_wr;
        grant <= sel;
        last_grant <= sel;
      end
      m0_read_done <= fin && !kind_wr && !grant;
      m0_write_done <= fin && kind_wr && !grant;
      m1_read_done <= fin && !kind_wr && grant;
      m1_write_done <= fin && kind_wr && grant;
      timeout_err <= fire;
      if (fin && !kind_wr && !grant) m0_read_data <= hit ? io_read_data : TO_DATA;
      if (fin && !kind_wr && grant) m1_read_data <= hit ? io_read_data : TO_DATA;
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: scoreboard bench; a cycle-level transaction model predicts strobes
// and completions from the bench's own requests and sequencer responses.
module tb_io_bus_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] TOD = 32'hFFFF_FFFF;
  typedef struct {int cyc; int m; bit wr; logic [15:0] a; logic [2:0] l; logic [31:0] d;} st_t;
  typedef struct {int cyc; int m; bit wr; logic [31:0] d; bit to;} dn_t;
  logic clk, reset_n;
  logic [1:0] rd_do, wr_do, rdone, wdone;
  logic [15:0] rd_addr[2], wr_addr[2];
  logic [2:0] rd_len[2], wr_len[2];
  logic [31:0] wr_data[2], rdata[2];
  logic r0d, r1d, w0d, w1d;
  logic [31:0] rd0, rd1;
  logic io_read_do, io_write_do, io_read_done, io_write_done, timeout_err, grant;
  logic [15:0] io_address;
  logic [2:0] io_length;
  logic [31:0] io_write_data, io_read_data;
  int checks = 0, errors = 0, cyc = 0, to_seen = 0;
  int fix_dly = 0;
  bit fix_rd = 0, pers = 0, run = 0;
  logic [31:0] fix_val = 0;
  st_t sq[$];
  dn_t dq[$];
  int gseq[$];
  bit kseq[$];
  logic [31:0] mon_rd[2];
  bit m_busy = 0;
  assign rdone = {r1d, r0d};
  assign wdone = {w1d, w0d};
  assign rdata[0] = rd0;
  assign rdata[1] = rd1;

  io_bus_arbiter #(.TIMEOUT(TO), .TO_DATA(TOD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read_do(rd_do[0]), .m0_read_address(rd_addr[0]), .m0_read_length(rd_len[0]),
    .m0_read_data(rd0), .m0_read_done(r0d),
    .m0_write_do(wr_do[0]), .m0_write_address(wr_addr[0]), .m0_write_length(wr_len[0]),
    .m0_write_data(wr_data[0]), .m0_write_done(w0d),
    .m1_read_do(rd_do[1]), .m1_read_address(rd_addr[1]), .m1_read_length(rd_len[1]),
    .m1_read_data(rd1), .m1_read_done(r1d),
    .m1_write_do(wr_do[1]), .m1_write_address(wr_addr[1]), .m1_write_length(wr_len[1]),
    .m1_write_data(wr_data[1]), .m1_write_done(w1d),
    .io_read_do(io_read_do), .io_write_do(io_write_do), .io_address(io_address),
    .io_length(io_length), .io_write_data(io_write_data), .io_read_data(io_read_data),
    .io_read_done(io_read_done), .io_write_done(io_write_done),
    .timeout_err(timeout_err), .grant(grant)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic outs_nz();
    return |{rd0, rd1, rdone, wdone, io_read_do, io_write_do, io_address, io_length,
             io_write_data, timeout_err, grant};
  endfunction

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    return r < 7 ? $urandom_range(1, 6) : r == 7 ? TO : $urandom_range(TO + 1, TO + 5);
  endfunction

  // sequencer: answers each strobe after a delay; late answers exercise the watchdog
  initial begin
    bit sp = 0, sk = 0;
    int sdue = 0;
    io_read_done = 0;
    io_write_done = 0;
    io_read_data = 0;
    forever begin
      @(posedge clk);
      #1;
      io_read_done = 0;
      io_write_done = 0;
      io_read_data = fix_rd ? fix_val : $urandom;
      if (reset_n && sp && cyc == sdue) begin
        if (sk) io_write_done = 1;
        else io_read_done = 1;
        sp = 0;
      end
      @(negedge clk);
      if (!reset_n) sp = 0;
      else if (io_read_do | io_write_do) begin
        sp = 1;
        sk = io_write_do;
        sdue = cyc + (fix_dly != 0 ? fix_dly : pick_delay());
      end
    end
  end

  // reference model: one transaction at a time, round-robin on ties, timed by cycle arithmetic
  initial begin
    int free_at = 0, s_cyc = 0, own = 0;
    bit lastg = 1, kind = 0, drain = 0, p0, p1, dh;
    st_t s;
    dn_t d;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 0;
        drain = 0;
        lastg = 1;
        free_at = 0;
        sq.delete();
        dq.delete();
      end else if (!m_busy) begin
        p0 = rd_do[0] | wr_do[0];
        p1 = rd_do[1] | wr_do[1];
        if (cyc >= free_at && (p0 || p1)) begin
          own = (p0 && p1) ? int'(!lastg) : int'(p1);
          kind = wr_do[own];
          s.cyc = cyc + 1;
          s.m = own;
          s.wr = kind;
          s.a = kind ? wr_addr[own] : rd_addr[own];
          s.l = kind ? wr_len[own] : rd_len[own];
          s.d = wr_data[own];
          sq.push_back(s);
          lastg = own[0];
          s_cyc = cyc + 1;
          m_busy = 1;
          drain = 0;
        end
      end else begin
        dh = kind ? io_write_done : io_read_done;
        d.cyc = cyc + 1;
        d.m = own;
        d.wr = kind;
        if (drain) begin
          if (dh) begin
            m_busy = 0;
            free_at = cyc + 1;
          end
        end else if (cyc > s_cyc && dh) begin
          d.d = io_read_data;
          d.to = 0;
          dq.push_back(d);
          m_busy = 0;
          free_at = cyc + 2;
        end else if (cyc == s_cyc + TO) begin
          d.d = TOD;
          d.to = 1;
          dq.push_back(d);
          drain = 1;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT strobes or signals completion
  initial begin
    st_t s;
    dn_t d;
    mon_rd[0] = 0;
    mon_rd[1] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_rd[0] = 0;
        mon_rd[1] = 0;
      end else begin
        while (sq.size() != 0 && sq[0].cyc < cyc) begin
          chk("strobe_missing_cycle", cyc, sq[0].cyc);
          void'(sq.pop_front());
        end
        while (dq.size() != 0 && dq[0].cyc < cyc) begin
          chk("done_missing_cycle", cyc, dq[0].cyc);
          void'(dq.pop_front());
        end
        if (io_read_do | io_write_do) begin
          chk("strobe_single_kind", io_read_do & io_write_do, 0);
          if (sq.size() == 0) chk("strobe_unexpected", 1, 0);
          else begin
            s = sq.pop_front();
            chk("strobe_cycle", cyc, s.cyc);
            chk("strobe_kind", io_write_do, s.wr);
            chk("strobe_grant", grant, s.m);
            chk("strobe_address", io_address, s.a);
            chk("strobe_length", io_length, s.l);
            if (s.wr) chk("strobe_wdata", io_write_data, s.d);
          end
        end
        if (timeout_err) to_seen++;
        if (timeout_err && !(|rdone) && !(|wdone)) chk("timeout_without_done", 1, 0);
        for (int m = 0; m < 2; m++) begin
          if (rdone[m] | wdone[m]) begin
            chk("done_single_kind", rdone[m] & wdone[m], 0);
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
              d = dq.pop_front();
              chk("done_cycle", cyc, d.cyc);
              chk("done_owner", m, d.m);
              chk("done_kind", wdone[m], d.wr);
              chk("done_timeout_err", timeout_err, d.to);
              if (!d.wr) begin
                chk("read_data", rdata[m], d.d);
                mon_rd[m] = d.d;
              end
            end
            gseq.push_back(m);
            kseq.push_back(wdone[m]);
          end
          chk("read_data_hold", rdata[m], mon_rd[m]);
        end
      end
    end
  end

  // requesters drop a request on the cycle after seeing its done
  initial forever begin
    logic [1:0] r, w;
    @(negedge clk);
    r = rdone;
    w = wdone;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (r[m] && !pers) rd_do[m] = 0;
      if (w[m]) wr_do[m] = 0;
    end
  end

  task automatic requester(input int m);
    int k;
    forever begin
      @(posedge clk);
      #2;
      if (run && !rd_do[m] && !wr_do[m] && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 2);
        rd_addr[m] = 16'($urandom);
        wr_addr[m] = 16'($urandom);
        rd_len[m] = 3'($urandom_range(1, 4));
        wr_len[m] = 3'($urandom_range(1, 4));
        wr_data[m] = $urandom;
        rd_do[m] = (k != 1);
        wr_do[m] = (k != 0);
      end
    end
  endtask
  initial requester(0);
  initial requester(1);

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((rd_do | wr_do) != 0 || m_busy || sq.size() != 0 || dq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 600) begin
        chk({nm, "_idle_timeout"}, 1, 0);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_req(input int m, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [2:0] l, input logic [31:0] d);
    rd_addr[m] = a;
    wr_addr[m] = a;
    rd_len[m] = l;
    wr_len[m] = l;
    wr_data[m] = d;
    if (rd) rd_do[m] = 1;
    if (wr) wr_do[m] = 1;
  endtask

  initial begin
    int n, t0;
    reset_n = 0;
    rd_do = 0;
    wr_do = 0;
    for (int m = 0; m < 2; m++) begin
      rd_addr[m] = 0;
      wr_addr[m] = 0;
      rd_len[m] = 1;
      wr_len[m] = 1;
      wr_data[m] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_nz(), 0);
    reset_n = 1;
    fix_dly = 3;
    // contention: both write from the same cycle, m0 first after reset
    @(posedge clk);
    #1;
    set_req(0, 0, 1, 16'h0010, 3'd4, 32'h1122_3344);
    set_req(1, 0, 1, 16'h0020, 3'd4, 32'h5566_7788);
    wait_idle("contention");
    chk("contention_count", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("contention_first", gseq[0], 0);
      chk("contention_second", gseq[1], 1);
    end
    // single read
    gseq.delete();
    fix_rd = 1;
    fix_val = 32'h0000_00AB;
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 16'h0060, 3'd1, 32'h0);
    wait_idle("single_read");
    chk("single_read_data", rdata[0], 32'h0000_00AB);
    chk("single_read_m1_data", rdata[1], 32'h0);
    chk("single_read_count", gseq.size(), 1);
    fix_rd = 0;
    // read and write together on m1: write first
    gseq.delete();
    kseq.delete();
    @(posedge clk);
    #1;
    set_req(1, 1, 1, 16'h0044, 3'd2, 32'hCAFE_F00D);
    wait_idle("rd_wr_m1");
    chk("rdwr_count", kseq.size(), 2);
    if (kseq.size() == 2) begin
      chk("rdwr_first_is_write", kseq[0], 1);
      chk("rdwr_second_is_read", kseq[1], 0);
      chk("rdwr_owner", gseq[0] + gseq[1], 2);
    end
    // sustained contention: reads held continuously
    gseq.delete();
    pers = 1;
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 16'h0100, 3'd1, 32'h0);
    set_req(1, 1, 0, 16'h0200, 3'd2, 32'h0);
    n = 0;
    while (gseq.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("sustained_reached", gseq.size() >= 6, 1);
    if (gseq.size() >= 6) for (int i = 0; i < 6; i++) chk("sustained_grant", gseq[i], i % 2);
    @(posedge clk);
    #1;
    pers = 0;
    wait_idle("sustained");
    // watchdog: done arrives late and is drained
    t0 = to_seen;
    fix_dly = 12;
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 16'h0300, 3'd4, 32'h0);
    wait_idle("timeout");
    chk("timeout_pulses", to_seen - t0, 1);
    chk("timeout_read_data", rdata[0], TOD);
    gseq.delete();
    fix_dly = 3;
    @(posedge clk);
    #1;
    set_req(1, 0, 1, 16'h0304, 3'd4, 32'hA5A5_5A5A);
    wait_idle("after_timeout");
    chk("after_timeout_served", gseq.size(), 1);
    // done on the last watchdog cycle wins
    t0 = to_seen;
    fix_dly = TO;
    fix_rd = 1;
    fix_val = 32'h1234_5678;
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 16'h0400, 3'd3, 32'h0);
    wait_idle("boundary");
    chk("boundary_no_timeout", to_seen - t0, 0);
    chk("boundary_read_data", rdata[0], 32'h1234_5678);
    fix_rd = 0;
    // asynchronous reset in the middle of BUSY
    fix_dly = 30;
    @(posedge clk);
    #1;
    set_req(1, 1, 0, 16'h0500, 3'd1, 32'h0);
    n = 0;
    while (!io_read_do && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_strobe", io_read_do, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("async_reset_outputs", outs_nz(), 0);
    set_req(0, 1, 0, 16'h0600, 3'd2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    gseq.delete();
    fix_dly = 3;
    reset_n = 1;
    wait_idle("post_reset");
    chk("post_reset_count", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("post_reset_first_m0", gseq[0], 0);
      chk("post_reset_second_m1", gseq[1], 1);
    end
    // randomized traffic
    fix_dly = 0;
    run = 1;
    repeat (3000) @(posedge clk);
    run = 0;
    wait_idle("random");
    chk("strobe_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
